// File: rtl/sd_pkg.sv
// Shared SD definitions: frame field widths, CRC7 polynomial and step, FSM states.
package sd_pkg;

  localparam int SD_IDX_W   = 6;
  localparam int SD_ARG_W   = 32;
  localparam int SD_CRC_W   = 7;
  localparam int SD_FRAME_W = 2 + SD_IDX_W + SD_ARG_W + SD_CRC_W + 1;

  // x^7 + x^3 + 1 with the x^7 term implicit
  localparam logic [SD_CRC_W-1:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    CRC,
    END,
    GAP
  } sd_tx_state_t;

  // One serial CRC7 step for a single data bit
  function automatic logic [SD_CRC_W-1:0] crc7_step(input logic [SD_CRC_W-1:0] crc,
                                                    input logic bit_in);
    logic fb;
    fb = crc[SD_CRC_W-1] ^ bit_in;
    return {crc[SD_CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
  endfunction

endpackage

// File: rtl/sd_cmd_frame_tx_if.sv
// Command request / CMD pad bus between the command sequencer and the frame transmitter.
interface sd_cmd_frame_tx_if #(
  parameter int IDX_W = 6,
  parameter int ARG_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IDX_W-1:0] cmd_index;
  logic [ARG_W-1:0] cmd_arg;
  logic             abort;
  logic             cmd_so;
  logic             cmd_oe;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_index, cmd_arg, abort,
    input  cmd_ready, cmd_so, cmd_oe, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, abort,
    output cmd_ready, cmd_so, cmd_oe, busy, done
  );
endinterface

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 generator; clear and enable together restart the CRC with the given bit.
module sd_crc7_serial
  import sd_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic                i_bit,
  output logic [SD_CRC_W-1:0] o_crc
);

  logic [SD_CRC_W-1:0] r_crc;
  logic [SD_CRC_W-1:0] w_base;

  assign w_base = i_clr ? '0 : r_crc;

  // CRC register, updated on the falling edge like the rest of the CMD path
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_crc <= '0;
    end else if (i_clr || i_en) begin
      r_crc <= i_en ? crc7_step(w_base, i_bit) : '0;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_cmd_frame_tx.sv
// SD CMD-line frame transmitter: preamble ones, start/dir/index/arg, CRC7, end bit, gap ones.
module sd_cmd_frame_tx
  import sd_pkg::*;
#(
  parameter int IDX_W    = SD_IDX_W,
  parameter int ARG_W    = SD_ARG_W,
  parameter int PRE_BITS = 2,
  parameter int GAP_BITS = 8,
  parameter int CRC_EN   = 1
) (
  input  logic               clk,
  input  logic               reset,
  sd_cmd_frame_tx_if.slave   bus
);

  localparam int HDR_W   = 2 + IDX_W + ARG_W;
  localparam int FRAME_W = HDR_W + SD_CRC_W + 1;
  localparam int MAX_PG  = (PRE_BITS > GAP_BITS) ? PRE_BITS : GAP_BITS;
  localparam int MAX_CNT = (MAX_PG > HDR_W) ? MAX_PG : HDR_W;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'((PRE_BITS > 0) ? PRE_BITS - 1 : 0);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(SD_CRC_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_BITS - 1);

  sd_tx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [FRAME_W-1:0]  r_sh, w_sh_nxt, w_sh_src, w_load;
  logic                r_so, r_oe, r_done;
  logic                w_so_nxt, w_oe_nxt, w_done_nxt;
  logic                w_accept;
  logic                w_crc_clr, w_crc_en, w_crc_bit;
  logic [SD_CRC_W-1:0] w_crc, w_crc_field, w_crc_sh;

  // Header bits first; the trailing ones are never shifted onto the line
  assign w_load      = {2'b01, bus.cmd_index, bus.cmd_arg, {(SD_CRC_W + 1){1'b1}}};
  assign w_accept    = bus.cmd_valid && (r_state == IDLE);
  assign w_crc_field = (CRC_EN != 0) ? w_crc : '1;
  assign w_crc_sh    = w_crc_field << w_cnt_nxt;

  sd_crc7_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_bit (w_crc_bit),
    .o_crc (w_crc)
  );

  // Next state, counter, shift register and the line value for the coming period
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_sh_src    = r_sh;
    w_sh_nxt    = r_sh;
    w_crc_clr   = 1'b0;
    w_crc_en    = 1'b0;
    w_crc_bit   = 1'b1;
    w_so_nxt    = 1'b1;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = r_cnt;
        if (w_accept) begin
          w_crc_clr   = 1'b1;
          w_sh_src    = w_load;
          w_sh_nxt    = w_load;
          w_cnt_nxt   = '0;
          w_state_nxt = (PRE_BITS > 0) ? PRE : HDR;
        end
      end
      PRE: if (r_cnt == PRE_LAST) begin w_state_nxt = HDR; w_cnt_nxt = '0; end
      HDR: if (r_cnt == HDR_LAST) begin w_state_nxt = CRC; w_cnt_nxt = '0; end
      CRC: if (r_cnt == CRC_LAST) begin w_state_nxt = END; w_cnt_nxt = '0; end
      END: begin w_state_nxt = GAP; w_cnt_nxt = '0; end
      GAP: if (r_cnt == GAP_LAST) begin w_state_nxt = IDLE; w_cnt_nxt = '0; end
      default: begin w_state_nxt = IDLE; w_cnt_nxt = '0; end
    endcase

    // Abort parks the line high and still runs the full release gap
    if (bus.abort && (r_state inside {PRE, HDR, CRC, END})) begin
      w_state_nxt = GAP;
      w_cnt_nxt   = '0;
    end

    if (w_state_nxt == HDR) begin
      w_so_nxt  = w_sh_src[FRAME_W-1];
      w_crc_en  = 1'b1;
      w_crc_bit = w_sh_src[FRAME_W-1];
      w_sh_nxt  = {w_sh_src[FRAME_W-2:0], 1'b1};
    end else if (w_state_nxt == CRC) begin
      w_so_nxt = w_crc_sh[SD_CRC_W-1];
    end

    w_oe_nxt   = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == IDLE) && (r_state != IDLE);
  end

  // State and output registers on the falling edge; the card samples on the rising edge
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '1;
      r_so    <= 1'b1;
      r_oe    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sh    <= w_sh_nxt;
      r_so    <= w_so_nxt;
      r_oe    <= w_oe_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.cmd_ready = !reset && (r_state == IDLE);
  assign bus.cmd_so    = r_so;
  assign bus.cmd_oe    = r_oe;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;

endmodule
